// File: rtl/uart_buffer_baud.sv
// UART support core: TX/RX bit-strobe generator plus RX and TX byte FIFOs
// between the host register interface and the serial shifters.
module uart_buffer_baud #(
  parameter int BAUD_DIV = 434,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bps_tx_en,
  input  logic       bps_rx_en,
  output logic       bps_tx_clk,
  output logic       bps_rx_clk,
  input  logic [7:0] rcv_din,
  input  logic       rcv_err,
  input  logic       en_rcv,
  input  logic       en_rd,
  output logic       empty_rcv,
  output logic [7:0] data_rcv,
  output logic       full_rcv,
  input  logic [7:0] data_in,
  input  logic       en_wr,
  output logic       write,
  output logic       full,
  output logic       empty,
  output logic [7:0] data_xmit,
  output logic       tx_start,
  input  logic       tx_done
);

  localparam int              CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]   RX_MID   = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     ZERO_CNT = {(AW + 1){1'b0}};
  localparam logic [AW-1:0]   PTR_ZERO = {AW{1'b0}};

  logic [CW-1:0] tx_cnt_r;
  logic [CW-1:0] tx_cnt_nxt_s;
  logic [CW-1:0] rx_cnt_r;
  logic [CW-1:0] rx_cnt_nxt_s;

  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr_r;
  logic [AW-1:0] rx_rd_ptr_r;
  logic [AW:0]   rx_count_r;
  logic [AW:0]   rx_count_nxt_s;
  logic          rx_push_s;
  logic          rx_pop_s;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr_r;
  logic [AW-1:0] tx_rd_ptr_r;
  logic [AW:0]   tx_count_r;
  logic [AW:0]   tx_count_nxt_s;
  logic          tx_busy_r;
  logic          tx_push_s;
  logic          tx_pop_s;
  logic          tx_fire_s;

  // Baud counter next state; a low enable parks the counter at zero.
  always_comb begin
    tx_cnt_nxt_s = CNT_ZERO;
    rx_cnt_nxt_s = CNT_ZERO;
    if (bps_tx_en && (tx_cnt_r != CNT_LAST)) begin
      tx_cnt_nxt_s = tx_cnt_r + 1'b1;
    end else begin
      tx_cnt_nxt_s = CNT_ZERO;
    end
    if (bps_rx_en && (rx_cnt_r != CNT_LAST)) begin
      rx_cnt_nxt_s = rx_cnt_r + 1'b1;
    end else begin
      rx_cnt_nxt_s = CNT_ZERO;
    end
  end

  // Strobes are registered so they coincide with the cycle the counter hits its tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt_r   <= CNT_ZERO;
      rx_cnt_r   <= CNT_ZERO;
      bps_tx_clk <= 1'b0;
      bps_rx_clk <= 1'b0;
    end else begin
      tx_cnt_r   <= tx_cnt_nxt_s;
      rx_cnt_r   <= rx_cnt_nxt_s;
      bps_tx_clk <= bps_tx_en && (tx_cnt_nxt_s == CNT_LAST);
      bps_rx_clk <= bps_rx_en && (rx_cnt_nxt_s == RX_MID);
    end
  end

  // RX FIFO request qualification and occupancy update.
  always_comb begin
    rx_push_s = !rst && en_rcv && !rcv_err && (rx_count_r != FULL_CNT);
    rx_pop_s  = !rst && en_rd && (rx_count_r != ZERO_CNT);
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_count_nxt_s = rx_count_r + 1'b1;
      2'b01:   rx_count_nxt_s = rx_count_r - 1'b1;
      default: rx_count_nxt_s = rx_count_r;
    endcase
  end

  // RX FIFO pointers, flags and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_r <= PTR_ZERO;
      rx_rd_ptr_r <= PTR_ZERO;
      rx_count_r  <= ZERO_CNT;
      empty_rcv   <= 1'b0;
      full_rcv    <= 1'b0;
      data_rcv    <= 8'h00;
    end else begin
      if (rx_push_s) begin
        rx_wr_ptr_r <= rx_wr_ptr_r + 1'b1;
      end
      if (rx_pop_s) begin
        data_rcv    <= rx_mem[rx_rd_ptr_r];
        rx_rd_ptr_r <= rx_rd_ptr_r + 1'b1;
      end
      rx_count_r <= rx_count_nxt_s;
      // empty_rcv is a data-present flag despite its name.
      empty_rcv  <= (rx_count_nxt_s != ZERO_CNT);
      full_rcv   <= (rx_count_nxt_s == FULL_CNT);
    end
  end

  // TX FIFO request qualification, transmitter kick-off and occupancy update.
  always_comb begin
    tx_push_s = !rst && en_wr && (tx_count_r != FULL_CNT);
    tx_pop_s  = !rst && tx_done && tx_busy_r;
    tx_fire_s = !rst && !empty && !tx_busy_r && !tx_start;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_nxt_s = tx_count_r + 1'b1;
      2'b01:   tx_count_nxt_s = tx_count_r - 1'b1;
      default: tx_count_nxt_s = tx_count_r;
    endcase
  end

  // TX FIFO pointers, flags, write acknowledge and start handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_r <= PTR_ZERO;
      tx_rd_ptr_r <= PTR_ZERO;
      tx_count_r  <= ZERO_CNT;
      tx_busy_r   <= 1'b0;
      write       <= 1'b0;
      full        <= 1'b0;
      empty       <= 1'b1;
      tx_start    <= 1'b0;
    end else begin
      write    <= tx_push_s;
      tx_start <= tx_fire_s;
      if (tx_pop_s) begin
        tx_busy_r   <= 1'b0;
        tx_rd_ptr_r <= tx_rd_ptr_r + 1'b1;
      end else if (tx_fire_s) begin
        tx_busy_r <= 1'b1;
      end
      if (tx_push_s) begin
        tx_wr_ptr_r <= tx_wr_ptr_r + 1'b1;
      end
      tx_count_r <= tx_count_nxt_s;
      full       <= (tx_count_nxt_s == FULL_CNT);
      empty      <= (tx_count_nxt_s == ZERO_CNT);
    end
  end

  // Byte storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (rx_push_s) begin
      rx_mem[rx_wr_ptr_r] <= rcv_din;
    end
    if (tx_push_s) begin
      tx_mem[tx_wr_ptr_r] <= data_in;
    end
  end

  // Show-ahead head byte for the transmitter.
  assign data_xmit = tx_mem[tx_rd_ptr_r];

endmodule

// File: tb/tb_uart_buffer_baud.sv
// Scoreboard bench for uart_buffer_baud: stimulus queues expected events,
// a negedge monitor pops and compares whenever the DUT emits one.
module tb_uart_buffer_baud;
  localparam int BAUD_DIV = 8;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       bps_tx_en, bps_rx_en, bps_tx_clk, bps_rx_clk;
  logic [7:0] rcv_din;
  logic       rcv_err, en_rcv, en_rd, empty_rcv, full_rcv;
  logic [7:0] data_rcv;
  logic [7:0] data_in;
  logic       en_wr, write, full, empty, tx_start, tx_done;
  logic [7:0] data_xmit;

  uart_buffer_baud #(.BAUD_DIV(BAUD_DIV), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .bps_tx_en(bps_tx_en), .bps_rx_en(bps_rx_en),
    .bps_tx_clk(bps_tx_clk), .bps_rx_clk(bps_rx_clk),
    .rcv_din(rcv_din), .rcv_err(rcv_err), .en_rcv(en_rcv), .en_rd(en_rd),
    .empty_rcv(empty_rcv), .data_rcv(data_rcv), .full_rcv(full_rcv),
    .data_in(data_in), .en_wr(en_wr), .write(write), .full(full), .empty(empty),
    .data_xmit(data_xmit), .tx_start(tx_start), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int n_start_seen = 0;
  int n_write_seen = 0;
  int exp_writes = 0;

  int         txs_q[$];
  int         rxs_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] start_q[$];

  logic       rd_seen = 1'b0;
  int         exp_cyc_m;
  logic [7:0] exp_byte_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: output event at cycle %0d, required none", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rcv_byte(input logic [7:0] b, input logic err);
    rcv_din = b; rcv_err = err; en_rcv = 1'b1;
    tick(1);
    en_rcv = 1'b0; rcv_err = 1'b0;
  endtask

  task automatic rd_byte(input logic [7:0] exp);
    rd_q.push_back(exp);
    en_rd = 1'b1;
    tick(1);
    en_rd = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
    data_in = b; en_wr = 1'b1;
    tick(1);
    en_wr = 1'b0;
    chk("write_ack", {31'd0, write}, {31'd0, exp_ack});
    if (exp_ack) exp_writes++;
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (n_start_seen < target && n < 60) begin
      tick(1);
      n++;
    end
    chk("tx_start_seen", 32'(n_start_seen), 32'(target));
  endtask

  always @(posedge clk) rd_seen <= en_rd;

  // Monitor: every DUT output event is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (bps_tx_clk === 1'b1) begin
      if (txs_q.size() == 0) unexpected("tx_strobe");
      else begin
        exp_cyc_m = txs_q.pop_front();
        chk("tx_strobe_cycle", 32'(cyc), 32'(exp_cyc_m));
      end
    end
    if (bps_rx_clk === 1'b1) begin
      if (rxs_q.size() == 0) unexpected("rx_strobe");
      else begin
        exp_cyc_m = rxs_q.pop_front();
        chk("rx_strobe_cycle", 32'(cyc), 32'(exp_cyc_m));
      end
    end
    if (rd_seen) begin
      if (rd_q.size() == 0) unexpected("rd_data");
      else begin
        exp_byte_m = rd_q.pop_front();
        chk("rd_data", {24'd0, data_rcv}, {24'd0, exp_byte_m});
      end
    end
    if (tx_start === 1'b1) begin
      n_start_seen++;
      if (start_q.size() == 0) unexpected("tx_start");
      else begin
        exp_byte_m = start_q.pop_front();
        chk("data_xmit_at_start", {24'd0, data_xmit}, {24'd0, exp_byte_m});
      end
    end
    if (write === 1'b1) n_write_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    rst = 1'b1; bps_tx_en = 1'b0; bps_rx_en = 1'b0;
    rcv_din = 8'h00; rcv_err = 1'b0; en_rcv = 1'b0; en_rd = 1'b0;
    data_in = 8'h00; en_wr = 1'b0; tx_done = 1'b0;
    tick(3);
    chk("rst_bps_tx_clk", {31'd0, bps_tx_clk}, 32'd0);
    chk("rst_bps_rx_clk", {31'd0, bps_rx_clk}, 32'd0);
    chk("rst_empty_rcv",  {31'd0, empty_rcv},  32'd0);
    chk("rst_full_rcv",   {31'd0, full_rcv},   32'd0);
    chk("rst_data_rcv",   {24'd0, data_rcv},   32'd0);
    chk("rst_write",      {31'd0, write},      32'd0);
    chk("rst_full",       {31'd0, full},       32'd0);
    chk("rst_empty",      {31'd0, empty},      32'd1);
    chk("rst_tx_start",   {31'd0, tx_start},   32'd0);
    rst = 1'b0;
    tick(1);

    // TX strobe: cycles 8,16,24,32,40 after enable
    t0 = cyc; bps_tx_en = 1'b1;
    for (int i = 0; i < 5; i++) txs_q.push_back(t0 + 8 * i + 7);
    tick(40);
    bps_tx_en = 1'b0;
    tick(12);

    // RX strobe: first at 4 cycles, then every 8; dropping enable restarts
    t0 = cyc; bps_rx_en = 1'b1;
    rxs_q.push_back(t0 + 3); rxs_q.push_back(t0 + 11); rxs_q.push_back(t0 + 19);
    tick(22);
    bps_rx_en = 1'b0;
    tick(2);
    t0 = cyc; bps_rx_en = 1'b1;
    rxs_q.push_back(t0 + 3);
    tick(8);
    bps_rx_en = 1'b0;
    tick(4);
    chk("tx_strobes_missing", 32'(txs_q.size()), 32'd0);
    chk("rx_strobes_missing", 32'(rxs_q.size()), 32'd0);

    // RX FIFO basic, error drop, read on empty
    rcv_byte(8'h41, 1'b0);
    rcv_byte(8'h42, 1'b0);
    rcv_byte(8'h99, 1'b1);
    chk("rx_data_present", {31'd0, empty_rcv}, 32'd1);
    rd_byte(8'h41);
    rd_byte(8'h42);
    chk("rx_drained", {31'd0, empty_rcv}, 32'd0);
    rd_byte(8'h42);
    tick(1);

    // RX fill past DEPTH
    for (int i = 0; i < DEPTH + 2; i++) begin
      rcv_byte(8'(8'h10 + i), 1'b0);
      if (i == DEPTH - 2) chk("rx_not_full_yet", {31'd0, full_rcv}, 32'd0);
      if (i == DEPTH - 1) chk("rx_full", {31'd0, full_rcv}, 32'd1);
    end
    chk("rx_full_held", {31'd0, full_rcv}, 32'd1);
    for (int i = 0; i < DEPTH; i++) rd_byte(8'(8'h10 + i));
    chk("rx_empty_after_fill", {31'd0, empty_rcv}, 32'd0);
    chk("rx_not_full_after", {31'd0, full_rcv}, 32'd0);

    // RX simultaneous read and write keeps count
    rcv_byte(8'h5A, 1'b0);
    rcv_din = 8'h5B; en_rcv = 1'b1; en_rd = 1'b1; rd_q.push_back(8'h5A);
    tick(1);
    en_rcv = 1'b0; en_rd = 1'b0;
    chk("rx_rw_count_kept", {31'd0, empty_rcv}, 32'd1);
    rd_byte(8'h5B);
    chk("rx_rw_drained", {31'd0, empty_rcv}, 32'd0);
    tick(1);

    // TX single byte
    base = n_start_seen;
    start_q.push_back(8'h55);
    wr_byte(8'h55, 1'b1);
    chk("tx_not_empty", {31'd0, empty}, 32'd0);
    wait_starts(base + 1);
    tick(10);
    chk("tx_no_restart", 32'(n_start_seen), 32'(base + 1));
    done_pulse();
    chk("tx_empty_after_done", {31'd0, empty}, 32'd1);
    tick(5);
    chk("tx_idle_no_start", 32'(n_start_seen), 32'(base + 1));

    // TX queue of three, one start per done
    base = n_start_seen;
    start_q.push_back(8'h01); start_q.push_back(8'h02); start_q.push_back(8'h03);
    wr_byte(8'h01, 1'b1);
    wr_byte(8'h02, 1'b1);
    wr_byte(8'h03, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_starts(base + i + 1);
      tick(10);
      done_pulse();
    end
    tick(5);
    chk("tx_queue_empty", {31'd0, empty}, 32'd1);
    chk("tx_queue_starts", 32'(n_start_seen), 32'(base + 3));

    // TX fill, write while full refused, then reset
    base = n_start_seen;
    start_q.push_back(8'hA0);
    for (int i = 0; i < DEPTH; i++) wr_byte(8'(8'hA0 + i), 1'b1);
    chk("tx_full", {31'd0, full}, 32'd1);
    wr_byte(8'hEE, 1'b0);
    chk("tx_full_held", {31'd0, full}, 32'd1);
    wait_starts(base + 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("tx_rst_empty", {31'd0, empty}, 32'd1);
    chk("tx_rst_full", {31'd0, full}, 32'd0);

    // Reset while busy with five queued; late tx_done is ignored
    base = n_start_seen;
    start_q.push_back(8'hC0);
    for (int i = 0; i < 5; i++) wr_byte(8'(8'hC0 + i), 1'b1);
    wait_starts(base + 1);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("busy_rst_empty", {31'd0, empty}, 32'd1);
    chk("busy_rst_full", {31'd0, full}, 32'd0);
    chk("busy_rst_tx_start", {31'd0, tx_start}, 32'd0);
    done_pulse();
    tick(5);
    chk("late_done_empty", {31'd0, empty}, 32'd1);
    chk("late_done_full", {31'd0, full}, 32'd0);
    chk("late_done_no_start", 32'(n_start_seen), 32'(base + 1));

    tick(2);
    chk("rd_pending", 32'(rd_q.size()), 32'd0);
    chk("start_pending", 32'(start_q.size()), 32'd0);
    chk("write_pulse_count", 32'(n_write_seen), 32'(exp_writes));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
